facelet_color_streamer: RTL
===========================

FACELET_COLOR_STREAMER -- requirements
Module: facelet_color_streamer

Interface
REQ-001 Parameters: NUM_FACELETS, 54, facelets stored and streamed per frame; FACELET_AW, 6, facelet address/index width.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clock  in  1  sole clock, all state updates on posedge.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 wr_en  in  1  write strobe for the color store.
REQ-006 wr_addr  in  6  facelet address to write, valid range 0..53.
REQ-007 wr_color  in  3  color code: W=0, O=1, G=2, Red=3, Blue=4, Y=5.
REQ-008 start  in  1  request to stream one full frame.
REQ-009 out_ready  in  1  downstream accepts the current beat.
REQ-010 out_valid  out  1  beat present on out_r/out_g/out_b/out_index/out_last.
REQ-011 out_r, out_g, out_b  out  8 each  RGB for the facelet.
REQ-012 out_index  out  6  facelet index of the beat.
REQ-013 out_last  out  1  high with the beat for index 53.
REQ-014 busy  out  1  high while not IDLE.
REQ-015 done  out  1  one-cycle pulse after the final beat transfers.
REQ-016 bad_code  out  1  sticky flag: a stored code 6 or 7 was streamed.

Function
REQ-017 Storage: 54 x 3-bit registers; a write with wr_en=1 and wr_addr<=53 SHALL update the entry on the next edge; wr_addr>=54 SHALL be ignored.
REQ-018 Writes SHALL be accepted in every state; an entry written before its LOAD cycle streams the new value.
REQ-019 A write to the entry being read in the same LOAD cycle SHALL yield the old value (read-before-write).
REQ-020 Code-to-RGB map: W=(255,255,255), O=(255,128,0), G=(0,255,0), Red=(255,0,0), Blue=(0,0,255), Y=(255,255,0); codes 6/7 -> (0,0,0) and set bad_code.
REQ-021 FSM states: IDLE, LOAD, SEND.
REQ-022 IDLE: start=1 -> LOAD with index=0; otherwise stay.
REQ-023 LOAD (one cycle): register RGB, out_index and out_last for the current index -> SEND.
REQ-024 SEND: out_valid=1; out_r/g/b, out_index, out_last SHALL stay stable until out_valid&out_ready.
REQ-025 SEND transfer with index<53 -> index+1, LOAD; with index=53 -> IDLE, done=1 in the following cycle.
REQ-026 Latency: start sampled at edge N -> out_valid high from cycle N+2; with out_ready held high a frame completes in 108 cycles, beats every second cycle.
REQ-027 start while busy=1 SHALL be ignored; start coinciding with the done pulse cycle (state IDLE) SHALL begin a new frame.
REQ-028 out_valid SHALL be 0 in IDLE and LOAD; out_ready is a don't-care outside SEND.
REQ-029 bad_code clears only on reset.

Reset
REQ-030 reset_n=0 at an edge SHALL force IDLE, index=0, out_valid=0, out_r/g/b=0, out_index=0, out_last=0, busy=0, done=0, bad_code=0, and clear all 54 entries to W (0).
REQ-031 Reset mid-frame SHALL abort the frame with no done pulse; reset SHALL take priority over write and start in the same cycle.

Structure
REQ-032 Shared package: color code constants W..Y, NUM_FACELETS, RGB constant table, FSM state enum.
REQ-033 One sub-module color_to_rgb (3-bit code in, 24-bit RGB plus invalid flag out, combinational) instantiated once.

Verification
REQ-034 Reset, write codes i mod 6 to all 54 addresses, start, out_ready=1 -> 54 beats, index 0..53, index 1 = (255,128,0), out_last only at 53, done once, cycle 109 after start.
REQ-035 Toggle out_ready 1-of-3 cycles mid-frame -> no beat lost or duplicated, data stable while out_valid&!out_ready.
REQ-036 Write code 7 to address 10, stream -> beat 10 = (0,0,0), bad_code rises after beat 10 and stays high through the next frame.
REQ-037 Write wr_addr=60 code 3 -> no entry changes; re-pulse start while busy -> single frame only.
REQ-038 During SEND of index 4, write address 20 code 4 -> beat 20 = (0,0,255); write address 5 in the LOAD cycle of index 5 -> old value streamed.
REQ-039 Assert reset_n=0 during SEND of index 30 -> next cycle IDLE, out_valid=0, no done; subsequent frame streams all W (255,255,255).

Source files
------------

// File: rtl/facelet_color_streamer_pkg.sv
// Shared definitions for the facelet color streamer: color codes, the RGB
// lookup table and the streaming FSM state encoding.
package facelet_color_streamer_pkg;

    localparam int NUM_FACELETS = 54;
    localparam int FACELET_AW   = 6;

    localparam logic [2:0] COLOR_W = 3'd0;
    localparam logic [2:0] COLOR_O = 3'd1;
    localparam logic [2:0] COLOR_G = 3'd2;
    localparam logic [2:0] COLOR_R = 3'd3;
    localparam logic [2:0] COLOR_B = 3'd4;
    localparam logic [2:0] COLOR_Y = 3'd5;

    localparam logic [23:0] RGB_W = 24'hFF_FF_FF;
    localparam logic [23:0] RGB_O = 24'hFF_80_00;
    localparam logic [23:0] RGB_G = 24'h00_FF_00;
    localparam logic [23:0] RGB_R = 24'hFF_00_00;
    localparam logic [23:0] RGB_B = 24'h00_00_FF;
    localparam logic [23:0] RGB_Y = 24'hFF_FF_00;

    // Entry k holds the RGB for color code k.
    localparam logic [5:0][23:0] RGB_TABLE = {RGB_Y, RGB_B, RGB_R, RGB_G, RGB_O, RGB_W};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

endpackage

// File: rtl/facelet_color_streamer_color_to_rgb.sv
// Combinational color-code to 24-bit RGB decoder; codes 6 and 7 decode to
// black and raise invalid.
module color_to_rgb
    import facelet_color_streamer_pkg::*;
(
    input  logic [2:0]  code,
    output logic [23:0] rgb,
    output logic        invalid
);

    always_comb begin
        rgb     = 24'h00_00_00;
        invalid = 1'b0;
        case (code)
            COLOR_W: rgb = RGB_TABLE[COLOR_W];
            COLOR_O: rgb = RGB_TABLE[COLOR_O];
            COLOR_G: rgb = RGB_TABLE[COLOR_G];
            COLOR_R: rgb = RGB_TABLE[COLOR_R];
            COLOR_B: rgb = RGB_TABLE[COLOR_B];
            COLOR_Y: rgb = RGB_TABLE[COLOR_Y];
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/facelet_color_streamer.sv
// Holds one 3-bit color per cube facelet and streams a full frame of RGB
// beats over a valid/ready port on each start request.
module facelet_color_streamer #(
    parameter int NUM_FACELETS = facelet_color_streamer_pkg::NUM_FACELETS,
    parameter int FACELET_AW   = facelet_color_streamer_pkg::FACELET_AW
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [FACELET_AW-1:0] wr_addr,
    input  logic [2:0]            wr_color,
    input  logic                  start,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [7:0]            out_r,
    output logic [7:0]            out_g,
    output logic [7:0]            out_b,
    output logic [FACELET_AW-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  bad_code
);
    import facelet_color_streamer_pkg::*;

    localparam logic [FACELET_AW-1:0] LAST_IDX = FACELET_AW'(NUM_FACELETS - 1);

    state_t                state, state_nx;
    logic [FACELET_AW-1:0] idx, idx_nx;
    logic [2:0]            mem [NUM_FACELETS];
    logic [23:0]           load_rgb;
    logic                  load_invalid;
    logic                  beat_bad;
    logic                  xfer;

    color_to_rgb u_color_to_rgb (
        .code    (mem[idx]),
        .rgb     (load_rgb),
        .invalid (load_invalid)
    );

    // Handshake: a beat transfers on a clock edge where out_valid and out_ready
    // are both high; while out_valid is high and out_ready low the beat holds.
    assign out_valid = (state == ST_SEND);
    assign xfer      = out_valid && out_ready;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_LOAD;
                    idx_nx   = '0;
                end
            end
            ST_LOAD: state_nx = ST_SEND;
            ST_SEND: begin
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_LOAD;
                        idx_nx   = idx + FACELET_AW'(1);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // The LOAD read sees the pre-edge contents, so a same-cycle write streams later.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_FACELETS; i++) begin
                mem[i] <= COLOR_W;
            end
        end else if (wr_en && (wr_addr <= LAST_IDX)) begin
            mem[wr_addr] <= wr_color;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            beat_bad  <= 1'b0;
            done      <= 1'b0;
            bad_code  <= 1'b0;
        end else begin
            done <= xfer && (idx == LAST_IDX);
            if (state == ST_LOAD) begin
                {out_r, out_g, out_b} <= load_rgb;
                out_index             <= idx;
                out_last              <= (idx == LAST_IDX);
                beat_bad              <= load_invalid;
            end
            // An undefined code counts as streamed once its beat is accepted.
            if (xfer && beat_bad) begin
                bad_code <= 1'b1;
            end
        end
    end

endmodule
